topk_dedup: RTL and testbench

- Parametrised successor to the gesture-stream duplicate filter. Takes a frame of TOPK class indices from the classifier ranking stage.
- Compares the frame's class set against a history of the last HIST_DEPTH accepted frames. A frame is "novel" when its unique-index overlap with every valid history entry is below a runtime threshold.
- Sits between top-K selection and the character/command emitter. Gates the emitter's advance strobe.
- Adds over the previous generation: configurable K/classes/history depth, a runtime threshold, a history-update mode, a clear input, overlap reporting and a valid/ready handshake.

---
 rtl/topk_dedup.sv | 149 ++++++++++++++
 tb/tb_topk_dedup.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/topk_dedup.sv
// Top-K frame duplicate filter: compares each frame's class set against recently
// accepted frames and flags frames whose overlap stays below a runtime threshold.
module topk_dedup #(
  parameter int NUM_CLASSES = 32,
  parameter int IDX_W       = 5,
  parameter int TOPK        = 3,
  parameter int HIST_DEPTH  = 2,
  parameter int CNT_W       = $clog2(TOPK + 1)
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [TOPK-1:0][IDX_W-1:0] i_tops,
  input  logic [CNT_W-1:0]           i_thresh,
  input  logic                       i_mode,
  input  logic                       i_clear,
  output logic                       o_valid,
  output logic                       o_next,
  output logic [CNT_W-1:0]           o_overlap
);

  localparam int J_W = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, MASK, CHECK, DONE} state_t;

  state_t                     state;
  state_t                     state_nx;
  logic [TOPK-1:0][IDX_W-1:0] tops;
  logic [CNT_W-1:0]           thresh;
  logic                       mode;
  logic [NUM_CLASSES-1:0]     mask;
  logic [NUM_CLASSES-1:0]     mask_build;
  logic [NUM_CLASSES-1:0]     hist [HIST_DEPTH];
  logic [HIST_DEPTH-1:0]      hist_valid;
  logic [J_W-1:0]             j;
  logic                       clear_pend;
  logic [CNT_W-1:0]           max_ov;
  logic [CNT_W-1:0]           ov;
  logic [CNT_W-1:0]           max_nx;
  logic                       last;
  logic                       accept;
  logic                       push;
  logic                       wipe;

  assign accept = i_valid && (state == IDLE);
  assign last   = (j == J_W'(HIST_DEPTH - 1));
  assign wipe   = clear_pend || i_clear;
  assign push   = !mode || o_next;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = MASK;
      MASK:    state_nx = CHECK;
      CHECK:   if (last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    o_ready = (state == IDLE);
    o_valid = (state == DONE);
  end

  // Scanning over class numbers means duplicates collapse and out-of-range indices never match.
  always_comb begin
    mask_build = '0;
    for (int c = 0; c < NUM_CLASSES; c++) begin
      for (int k = 0; k < TOPK; k++) begin
        if (tops[k] == IDX_W'(c)) mask_build[c] = 1'b1;
      end
    end
  end

  always_comb begin
    ov = '0;
    if (hist_valid[j]) begin
      for (int c = 0; c < NUM_CLASSES; c++) begin
        ov = ov + CNT_W'(mask[c] & hist[j][c]);
      end
    end
    max_nx = (ov > max_ov) ? ov : max_ov;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      tops       <= '0;
      thresh     <= '0;
      mode       <= 1'b0;
      mask       <= '0;
      j          <= '0;
      max_ov     <= '0;
      clear_pend <= 1'b0;
      hist_valid <= '0;
      o_next     <= 1'b0;
      o_overlap  <= '0;
      for (int k = 0; k < HIST_DEPTH; k++) hist[k] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_clear) hist_valid <= '0;
          if (accept) begin
            tops   <= i_tops;
            thresh <= i_thresh;
            mode   <= i_mode;
          end
        end
        MASK: begin
          mask   <= mask_build;
          max_ov <= '0;
          j      <= '0;
          if (i_clear) clear_pend <= 1'b1;
        end
        CHECK: begin
          max_ov <= max_nx;
          j      <= j + 1'b1;
          if (i_clear) clear_pend <= 1'b1;
          if (last) begin
            o_overlap <= max_nx;
            o_next    <= (max_nx < thresh);
          end
        end
        DONE: begin
          // A clear seen while the frame was in flight wins over pushing that frame.
          clear_pend <= 1'b0;
          if (wipe) begin
            hist_valid <= '0;
          end else if (push) begin
            for (int k = HIST_DEPTH - 1; k > 0; k--) begin
              hist[k]       <= hist[k-1];
              hist_valid[k] <= hist_valid[k-1];
            end
            hist[0]       <= mask;
            hist_valid[0] <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_topk_dedup.sv
// Directed bench for topk_dedup with NUM_CLASSES=30 so that index 31 is out of range.
module tb_topk_dedup;

  localparam int NUM_CLASSES = 30;
  localparam int IDX_W       = 5;
  localparam int TOPK        = 3;
  localparam int HIST_DEPTH  = 2;
  localparam int CNT_W       = 2;

  logic                       i_clk = 1'b0;
  logic                       i_rst_n = 1'b0;
  logic                       i_valid = 1'b0;
  logic                       o_ready;
  logic [TOPK-1:0][IDX_W-1:0] i_tops = '0;
  logic [CNT_W-1:0]           i_thresh = '0;
  logic                       i_mode = 1'b0;
  logic                       i_clear = 1'b0;
  logic                       o_valid;
  logic                       o_next;
  logic [CNT_W-1:0]           o_overlap;

  int checks = 0;
  int passed = 0;
  int failed = 0;

  topk_dedup #(
    .NUM_CLASSES(NUM_CLASSES),
    .IDX_W      (IDX_W),
    .TOPK       (TOPK),
    .HIST_DEPTH (HIST_DEPTH),
    .CNT_W      (CNT_W)
  ) dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_tops   (i_tops),
    .i_thresh (i_thresh),
    .i_mode   (i_mode),
    .i_clear  (i_clear),
    .o_valid  (o_valid),
    .o_next   (o_next),
    .o_overlap(o_overlap)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // cm: 0 no clear, 1 clear together with the accept, 2 clear pulsed during the first CHECK cycle
  task automatic apply_stimulus(input logic [IDX_W-1:0] a, input logic [IDX_W-1:0] b,
                                input logic [IDX_W-1:0] c, input int th, input bit md,
                                input int cm, input int exp_ov, input bit exp_next,
                                input string tag);
    int cycles;
    i_tops   = {c, b, a};
    i_thresh = CNT_W'(th);
    i_mode   = md;
    i_valid  = 1'b1;
    i_clear  = (cm == 1);
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    i_clear = 1'b0;
    i_tops  = {5'd17, 5'd18, 5'd19};
    check_output({tag, "_busy"}, o_ready, 0);
    cycles = 1;
    do begin
      @(posedge i_clk); #1;
      cycles++;
      i_clear = (cm == 2 && cycles == 2);
    end while (o_valid !== 1'b1 && cycles < 12);
    i_clear = 1'b0;
    check_output({tag, "_latency"}, cycles, 4);
    check_output({tag, "_ready_done"}, o_ready, 0);
    check_output({tag, "_overlap"}, o_overlap, exp_ov);
    check_output({tag, "_next"}, o_next, exp_next);
    @(posedge i_clk); #1;
    check_output({tag, "_valid_drop"}, o_valid, 0);
    check_output({tag, "_ready_back"}, o_ready, 1);
    check_output({tag, "_next_hold"}, o_next, exp_next);
  endtask

  initial begin
    int seen;
    i_rst_n = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    check_output("rst_ready", o_ready, 1);
    check_output("rst_valid", o_valid, 0);
    check_output("rst_next", o_next, 0);
    check_output("rst_overlap", o_overlap, 0);

    apply_stimulus(5'd1, 5'd2, 5'd3, 2, 1'b0, 0, 0, 1'b1, "f1_first");
    apply_stimulus(5'd1, 5'd2, 5'd7, 2, 1'b0, 0, 2, 1'b0, "f2_dup");
    apply_stimulus(5'd8, 5'd9, 5'd10, 2, 1'b0, 0, 0, 1'b1, "f3_new");
    apply_stimulus(5'd11, 5'd12, 5'd13, 2, 1'b0, 0, 0, 1'b1, "f4_new");
    apply_stimulus(5'd1, 5'd2, 5'd3, 2, 1'b0, 0, 0, 1'b1, "f5_aged_out");

    i_clear = 1'b1;
    @(posedge i_clk); #1;
    i_clear = 1'b0;
    check_output("idle_clear_ready", o_ready, 1);

    apply_stimulus(5'd4, 5'd5, 5'd6, 2, 1'b0, 0, 0, 1'b1, "f6_after_clear");
    apply_stimulus(5'd4, 5'd4, 5'd4, 2, 1'b0, 0, 1, 1'b1, "f7_unique_t2");
    apply_stimulus(5'd4, 5'd4, 5'd4, 1, 1'b0, 0, 1, 1'b0, "f8_unique_t1");

    apply_stimulus(5'd1, 5'd2, 5'd3, 2, 1'b1, 1, 0, 1'b1, "f9_mode1_seed");
    apply_stimulus(5'd1, 5'd2, 5'd9, 2, 1'b1, 0, 2, 1'b0, "f10_mode1_dup");
    apply_stimulus(5'd1, 5'd2, 5'd9, 2, 1'b1, 0, 2, 1'b0, "f11_mode1_dup");
    apply_stimulus(5'd9, 5'd20, 5'd21, 1, 1'b1, 0, 0, 1'b1, "f12_not_pushed");

    apply_stimulus(5'd0, 5'd1, 5'd2, 2, 1'b0, 1, 0, 1'b1, "f13_seed");
    apply_stimulus(5'd31, 5'd0, 5'd1, 2, 1'b0, 0, 2, 1'b0, "f14_drop_idx");
    apply_stimulus(5'd31, 5'd0, 5'd1, 3, 1'b0, 0, 2, 1'b1, "f15_thresh3");
    apply_stimulus(5'd5, 5'd6, 5'd7, 0, 1'b0, 1, 0, 1'b0, "f16_thresh0");

    apply_stimulus(5'd1, 5'd2, 5'd3, 2, 1'b0, 1, 0, 1'b1, "f17_seed");
    apply_stimulus(5'd1, 5'd2, 5'd3, 2, 1'b0, 2, 3, 1'b0, "f18_clear_check");
    apply_stimulus(5'd1, 5'd2, 5'd3, 2, 1'b0, 0, 0, 1'b1, "f19_cleared");

    i_tops   = {5'd3, 5'd2, 5'd1};
    i_thresh = 2'd2;
    i_mode   = 1'b0;
    i_valid  = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    @(posedge i_clk); #1;
    i_rst_n = 1'b0;
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    check_output("midrst_ready", o_ready, 1);
    check_output("midrst_overlap", o_overlap, 0);
    seen = 0;
    for (int n = 0; n < 6; n++) begin
      if (o_valid === 1'b1) seen++;
      @(posedge i_clk); #1;
    end
    check_output("midrst_no_valid", seen, 0);

    apply_stimulus(5'd1, 5'd2, 5'd3, 2, 1'b0, 0, 0, 1'b1, "f20_post_reset");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
